// File: rtl/tx_pkg.sv
// Shared types and frame constants for the 8N1 transmit path.
package tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register; load wins over shift, ones fill behind the data.
module flex_pts_sr #(
  parameter int unsigned NUM_BITS  = 4,
  parameter bit          SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                load_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= '1;
    end else if (load_enable) begin
      q <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) q <= {q[NUM_BITS-2:0], 1'b1};
      else           q <= {1'b1, q[NUM_BITS-1:1]};
    end
  end

  assign serial_out = SHIFT_MSB ? q[NUM_BITS-1] : q[0];

endmodule

// File: rtl/tx_frame_ctrl.sv
// 8N1 frame controller: bit-period and bit counters driving an LSB-first serializer.
module tx_frame_ctrl
  import tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int unsigned    CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     BIT_LAST = 4'(FRAME_BITS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
  logic [3:0]       bit_cnt, bit_cnt_nx;
  logic             load_enable, shift_enable;
  logic             bit_end, frame_end, done_nx;

  assign bit_end   = (clk_cnt == CNT_LAST);
  assign frame_end = bit_end && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      clk_cnt    <= clk_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      frame_done <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    clk_cnt_nx   = clk_cnt;
    bit_cnt_nx   = bit_cnt;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    tx_ready     = 1'b0;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          load_enable = 1'b1;
          clk_cnt_nx  = '0;
          bit_cnt_nx  = '0;
          state_nx    = SEND;
        end
      end
      SEND: begin
        tx_ready = frame_end;
        if (bit_end) begin
          shift_enable = 1'b1;
          clk_cnt_nx   = '0;
          bit_cnt_nx   = bit_cnt + 4'd1;
        end else begin
          clk_cnt_nx   = clk_cnt + CNT_W'(1);
        end
        // Stop-bit terminal cycle: either reload for a gapless next frame or fall back to IDLE.
        if (frame_end) begin
          done_nx    = 1'b1;
          bit_cnt_nx = '0;
          if (tx_valid) begin
            load_enable  = 1'b1;
            shift_enable = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx_busy = (state == SEND);

  flex_pts_sr #(
    .NUM_BITS (FRAME_BITS),
    .SHIFT_MSB(1'b0)
  ) u_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_enable),
    .load_enable (load_enable),
    .parallel_in ({STOP_BIT, tx_data, START_BIT}),
    .serial_out  (tx_out)
  );

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl: one instance at 4 clocks/bit, one at 2 clocks/bit.
module tb_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, out_a, busy_a, done_a;
  logic       ready_b, out_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_frame_ctrl #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .n_rst(n_rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_out(out_a), .tx_busy(busy_a), .frame_done(done_a)
  );

  tx_frame_ctrl #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_out(out_b), .tx_busy(busy_b), .frame_done(done_b)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    #1 n_rst = 1'b0;
    #1;
    checks++; if (out_a !== 1'b1)   begin errors++; $display("FAIL reset_out_a: got %b expected 1", out_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b expected 1", ready_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done_a: got %b expected 0", done_a); end
    checks++; if (out_b !== 1'b1)   begin errors++; $display("FAIL reset_out_b: got %b expected 1", out_b); end
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b expected 1", ready_b); end
    step(); step();
    n_rst = 1'b1;
    step();
    checks++; if (out_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got out=%b busy=%b expected out=1 busy=0", out_a, busy_a); end
  endtask

  task automatic test_single_frame();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;  // 0xA5 framed, index 0 = start bit
    data_a = 8'hA5; valid_a = 1'b1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL single_ready_c0: got %b expected 1", ready_a); end
    step(); valid_a = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      if (c > 1) step();
      checks++;
      if (out_a !== ((c <= 40) ? exp_bits[(c-1)/4] : 1'b1)) begin
        errors++; $display("FAIL single_out c%0d: got %b expected %b", c, out_a, (c <= 40) ? exp_bits[(c-1)/4] : 1'b1);
      end
      checks++;
      if (busy_a !== (c <= 40)) begin errors++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy_a, c <= 40); end
      checks++;
      if (done_a !== (c == 41)) begin errors++; $display("FAIL single_done c%0d: got %b expected %b", c, done_a, c == 41); end
    end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL single_ready_c41: got %b expected 1", ready_a); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_bits;
    exp_bits = {10'b1001111000, 10'b1101001010};  // 0x3C frame after 0xA5 frame
    data_a = 8'hA5; valid_a = 1'b1;
    step();
    for (int c = 1; c <= 81; c++) begin
      if (c > 1) step();
      if (c == 1)  data_a = 8'h3C;
      if (c == 41) valid_a = 1'b0;
      checks++;
      if (out_a !== ((c <= 80) ? exp_bits[(c-1)/4] : 1'b1)) begin
        errors++; $display("FAIL b2b_out c%0d: got %b expected %b", c, out_a, (c <= 80) ? exp_bits[(c-1)/4] : 1'b1);
      end
      checks++;
      if (ready_a !== (c == 40 || c == 80 || c == 81)) begin
        errors++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, ready_a, c == 40 || c == 80 || c == 81);
      end
      checks++;
      if (busy_a !== (c <= 80)) begin errors++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy_a, c <= 80); end
      checks++;
      if (done_a !== (c == 41 || c == 81)) begin
        errors++; $display("FAIL b2b_done c%0d: got %b expected %b", c, done_a, c == 41 || c == 81);
      end
    end
  endtask

  task automatic test_ignore_midframe();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    data_a = 8'hA5; valid_a = 1'b1;
    step(); valid_a = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c > 1) step();
      if (c == 10) begin
        data_a = 8'h00; valid_a = 1'b1;
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL mid_ready c10: got %b expected 0", ready_a); end
      end
      if (c == 11) valid_a = 1'b0;
      checks++;
      if (out_a !== ((c <= 40) ? exp_bits[(c-1)/4] : 1'b1)) begin
        errors++; $display("FAIL mid_out c%0d: got %b expected %b", c, out_a, (c <= 40) ? exp_bits[(c-1)/4] : 1'b1);
      end
      checks++;
      if (busy_a !== (c <= 40)) begin errors++; $display("FAIL mid_busy c%0d: got %b expected %b", c, busy_a, c <= 40); end
      checks++;
      if (done_a !== (c == 41)) begin errors++; $display("FAIL mid_done c%0d: got %b expected %b", c, done_a, c == 41); end
    end
  endtask

  task automatic test_reset_midframe();
    data_a = 8'hA5; valid_a = 1'b1;
    step(); valid_a = 1'b0;
    for (int c = 2; c <= 17; c++) step();
    n_rst = 1'b0;
    #1;
    checks++; if (out_a !== 1'b1)   begin errors++; $display("FAIL rstmid_out: got %b expected 1", out_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready_a); end
    checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL rstmid_done: got %b expected 0", done_a); end
    step();
    n_rst = 1'b1; data_a = 8'h00; valid_a = 1'b1;
    step(); valid_a = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      if (c > 1) step();
      checks++;
      if (out_a !== (c > 36)) begin errors++; $display("FAIL rstmid_out c%0d: got %b expected %b", c, out_a, c > 36); end
      checks++;
      if (done_a !== (c == 41)) begin errors++; $display("FAIL rstmid_done c%0d: got %b expected %b", c, done_a, c == 41); end
    end
  endtask

  task automatic test_fast_ff();
    data_b = 8'hFF; valid_b = 1'b1;
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL fast_ready_c0: got %b expected 1", ready_b); end
    step(); valid_b = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) step();
      checks++;
      if (out_b !== (c > 2)) begin errors++; $display("FAIL fast_out c%0d: got %b expected %b", c, out_b, c > 2); end
      checks++;
      if (busy_b !== (c <= 20)) begin errors++; $display("FAIL fast_busy c%0d: got %b expected %b", c, busy_b, c <= 20); end
      checks++;
      if (done_b !== (c == 21)) begin errors++; $display("FAIL fast_done c%0d: got %b expected %b", c, done_b, c == 21); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_fast_ff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_ctrl.md
TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10: clock cycles per serial bit period; legal range 2..1023.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 tx_data  input  8  byte to transmit; sampled only on the accept cycle.
REQ-005 tx_valid  input  1  requester has a byte on tx_data.
REQ-006 tx_ready  output  1  block can accept a byte this cycle; accept = tx_valid && tx_ready.
REQ-007 tx_out  output  1  serial line; idle high.
REQ-008 tx_busy  output  1  high while a frame is in progress (state SEND).
REQ-009 frame_done  output  1  single-cycle pulse after a frame's stop bit completes.

Function
REQ-010 Frame format SHALL be 8N1, 10 bits: start bit 0, data LSB first, stop bit 1.
REQ-011 FSM SHALL have two states: IDLE and SEND.
REQ-012 In IDLE, tx_ready SHALL be 1. On accept, the block SHALL:
  - assert load_enable to the shifter in the same cycle with {1'b1, tx_data, 1'b0};
  - clear clk_cnt and bit_cnt;
  - enter SEND.
REQ-013 The start bit SHALL appear on tx_out in the cycle after accept. Each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-014 In SEND, clk_cnt SHALL count 0..CLKS_PER_BIT-1. At the terminal count:
  - shift_enable is asserted for one cycle;
  - clk_cnt wraps to 0;
  - bit_cnt increments.
REQ-015 bit_cnt SHALL be 4 bits and count 0..9. The terminal cycle of bit 9 (stop) ends the frame; the next state is IDLE unless a new byte is accepted.
REQ-016 In SEND, tx_ready SHALL be 1 only in the stop-bit terminal cycle. An accept there SHALL:
  - load the next frame (load_enable has priority over shift_enable);
  - restart the counters;
  - remain in SEND, giving gapless back-to-back frames.
REQ-017 tx_valid while tx_ready=0 SHALL be ignored; the requester holds tx_valid/tx_data until accepted.
REQ-018 frame_done SHALL be registered: high for exactly one cycle, the cycle after each stop-bit terminal cycle, including back-to-back frames.
REQ-019 Total frame latency SHALL be 10*CLKS_PER_BIT cycles from the cycle after accept.
REQ-020 Bits shifted in behind the frame SHALL be 1, so tx_out is high in IDLE.
REQ-021 clk_cnt width SHALL be $clog2(CLKS_PER_BIT). Counters SHALL never exceed their terminal values.

Reset
REQ-022 On n_rst low, with no clock required, the block SHALL force:
  - state IDLE;
  - clk_cnt=0, bit_cnt=0;
  - frame_done=0, tx_busy=0, tx_ready=1;
  - shifter contents all ones (tx_out=1).
REQ-023 Reset mid-frame SHALL abandon the frame with no frame_done. The first edge after release SHALL be able to accept.

Structure
REQ-024 Package tx_pkg SHALL hold the state enum (IDLE, SEND), FRAME_BITS=10, START_BIT=1'b0 and STOP_BIT=1'b1.
REQ-025 The serializer SHALL be one instance of flex_pts_sr with NUM_BITS=FRAME_BITS and SHIFT_MSB=0, sharing clk and n_rst; tx_out=serial_out.
REQ-026 The FSM and counters SHALL be in tx_frame_ctrl. No other sub-modules.

Verification (CLKS_PER_BIT=4, accept at cycle 0)
REQ-027 Send 0xA5 -> tx_out over cycles 1..40 = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy 1..40; frame_done only at cycle 41.
REQ-028 tx_valid held high with 0xA5 then 0x3C; second accept at cycle 40 -> 0x3C start bit at cycle 41 with no idle gap; frame_done at 41 and 81.
REQ-029 tx_valid pulsed at cycle 10 mid-frame -> tx_ready=0, no accept, frame unchanged, returns IDLE at cycle 41.
REQ-030 n_rst low at cycle 17 -> tx_out=1, tx_ready=1, tx_busy=0 immediately; no frame_done; new byte 0x00 accepted after release sends 0 for 36 cycles then 1.
REQ-031 Send 0xFF with CLKS_PER_BIT=2 -> tx_out 0 for cycles 1-2, then 1 through cycle 20; frame_done at 21.
